pmem_arbiter: RTL and testbench

Arbitrates the single physical-memory port (the cacheline adaptor) between the instruction cache and the data cache miss/writeback paths. Each cache controller issues full-line reads (and, for D, line writebacks) with a level-held read/write strobe and waits for a one-cycle resp pulse. This block registers the winning request, drives the shared port and routes the response back. It sits between both cache controllers and the cacheline adaptor.

---
 rtl/pmem_arbiter.sv | 100 ++++++++++
 tb/tb_pmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Shares the physical-memory (cacheline adaptor) port between the I-cache and D-cache.
// Ports: clk, rst (async active-low); i_* and d_* cache-side requests and responses;
//        pmem_* adaptor side; grant = current owner (00 none, 01 I, 10 D).
module pmem_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_addr-1:0] pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } state_t;

  state_t state;
  logic   last_d;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  // D wins when alone, or on a tie when I was served last.
  assign pick_d = d_req & (~i_req | ~last_d);

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      grant        <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= SERVE_D;
            grant        <= 2'b10;
            // read+write together is a writeback
            pmem_write   <= d_pmem_write;
            pmem_read    <= ~d_pmem_write;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
          end else if (i_req) begin
            state        <= SERVE_I;
            grant        <= 2'b01;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= i_pmem_address;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= RELEASE;
            grant      <= 2'b00;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            last_d     <= (state == SERVE_D);
          end
        end
        RELEASE: begin
          // Stale strobes from the just-served cache are ignored here.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_pmem_arbiter;

  localparam int SL = 256;
  localparam int SA = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [SA-1:0] i_pmem_address;
  logic [SL-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [SA-1:0] d_pmem_address;
  logic [SL-1:0] d_pmem_wdata;
  logic [SL-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [SA-1:0] pmem_address;
  logic [SL-1:0] pmem_wdata;
  logic [SL-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    grant;

  pmem_arbiter #(.s_line(SL), .s_addr(SA)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .grant          (grant)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [SL-1:0] act,
                     input logic [SL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who holds the port, what was captured,
  // and whether the one-cycle hold-off after a completion is pending.
  int            m_owner;
  int            m_last;
  bit            m_hold;
  bit            m_wr;
  logic [SA-1:0] m_addr;
  logic [SL-1:0] m_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0;
      m_last  = 1;
      m_hold  = 1'b0;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_last  = m_owner;
        m_owner = 0;
        m_hold  = 1'b1;
      end
    end else if (m_hold) begin
      m_hold = 1'b0;
    end else begin
      bit ir;
      bit dr;
      ir = i_pmem_read;
      dr = d_pmem_read | d_pmem_write;
      if (dr && (!ir || m_last == 1)) begin
        m_owner = 2;
        m_wr    = d_pmem_write;
        m_addr  = d_pmem_address;
        m_wdata = d_pmem_wdata;
      end else if (ir) begin
        m_owner = 1;
        m_wr    = 1'b0;
        m_addr  = i_pmem_address;
      end
    end
  end

  always @(negedge clk) begin
    chk("grant", grant, m_owner);
    chk("pmem_read", pmem_read, (m_owner != 0) && !m_wr);
    chk("pmem_write", pmem_write, (m_owner != 0) && m_wr);
    if (m_owner != 0)
      chk("pmem_address", pmem_address, m_addr);
    if (m_owner == 2 && m_wr)
      chk("pmem_wdata", pmem_wdata, m_wdata);
    if (!rst) begin
      chk("rst_address", pmem_address, 0);
      chk("rst_wdata", pmem_wdata, 0);
    end
    chk("i_resp", i_pmem_resp, (m_owner == 1) && pmem_resp);
    chk("d_resp", d_pmem_resp, (m_owner == 2) && pmem_resp);
    chk("i_rdata", i_pmem_rdata, pmem_rdata);
    chk("d_rdata", d_pmem_rdata, pmem_rdata);
    chk("strobe_excl", pmem_read & pmem_write, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  logic [SL-1:0] pat_ab;
  logic [SL-1:0] pat_55;

  initial begin
    pat_ab = {32{8'hAB}};
    pat_55 = {32{8'h55}};
    rst = 1'b0;
    i_pmem_read = 1'b0;
    i_pmem_address = '0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    step();
    step();
    look();
    chk("reset_grant", grant, 0);
    chk("reset_read", pmem_read, 0);
    chk("reset_write", pmem_write, 0);
    step();
    rst = 1'b1;

    // single I read, resp in the fourth serve cycle
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_1040;
    step();
    look();
    chk("t1_grant", grant, 2'b01);
    chk("t1_read", pmem_read, 1);
    chk("t1_addr", pmem_address, 32'h0000_1040);
    step();
    step();
    step();
    pmem_resp = 1'b1;
    pmem_rdata = pat_ab;
    look();
    chk("t1_iresp", i_pmem_resp, 1);
    chk("t1_irdata", i_pmem_rdata, pat_ab);
    chk("t1_dresp", d_pmem_resp, 0);
    step();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    look();
    chk("t1_read_off", pmem_read, 0);
    chk("t1_grant_off", grant, 0);

    // simultaneous I read and D write: D first (I served last)
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_4000;
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_2000;
    d_pmem_wdata = pat_55;
    step();
    step();
    look();
    chk("t2_grant_d", grant, 2'b10);
    chk("t2_write", pmem_write, 1);
    chk("t2_read", pmem_read, 0);
    chk("t2_wdata", pmem_wdata, pat_55);
    step();
    pmem_resp = 1'b1;
    look();
    chk("t2_dresp", d_pmem_resp, 1);
    chk("t2_iresp", i_pmem_resp, 0);
    step();
    pmem_resp = 1'b0;
    d_pmem_write = 1'b0;
    step();
    step();
    look();
    chk("t2_grant_i", grant, 2'b01);
    chk("t2_iaddr", pmem_address, 32'h0000_4000);
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;

    // tie after I: D, then tie after D: I
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_2100;
    step();
    step();
    look();
    chk("rr_grant_d", grant, 2'b10);
    chk("rr_dread", pmem_read, 1);
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    step();
    step();
    look();
    chk("rr_grant_i", grant, 2'b01);
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;

    // D holds its read one cycle past resp: no second transaction
    step();
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_2200;
    step();
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    look();
    chk("t3_release_read", pmem_read, 0);
    step();
    d_pmem_read = 1'b0;
    look();
    chk("t3_idle_read", pmem_read, 0);
    chk("t3_idle_grant", grant, 0);
    step();
    look();
    chk("t3_after_read", pmem_read, 0);

    // D changes its request mid-serve
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_2000;
    d_pmem_wdata = pat_ab;
    step();
    d_pmem_address = 32'h0000_3000;
    d_pmem_write = 1'b0;
    step();
    look();
    chk("t4_addr_held", pmem_address, 32'h0000_2000);
    chk("t4_write_held", pmem_write, 1);
    step();
    pmem_resp = 1'b1;
    look();
    chk("t4_dresp", d_pmem_resp, 1);
    step();
    pmem_resp = 1'b0;

    // spurious resp in IDLE, then read+write treated as write
    step();
    pmem_resp = 1'b1;
    look();
    chk("t5_iresp", i_pmem_resp, 0);
    chk("t5_dresp", d_pmem_resp, 0);
    step();
    pmem_resp = 1'b0;
    look();
    chk("t5_grant", grant, 0);
    d_pmem_read = 1'b1;
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_2400;
    step();
    look();
    chk("t5_write", pmem_write, 1);
    chk("t5_read", pmem_read, 0);
    step();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;

    // async reset in the middle of an I transaction
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_1080;
    step();
    step();
    look();
    chk("t6_read", pmem_read, 1);
    step();
    pmem_resp = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_read", pmem_read, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_addr", pmem_address, 0);
    chk("t6_rst_iresp", i_pmem_resp, 0);
    i_pmem_read = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    step();
    look();
    chk("t6_idle_iresp", i_pmem_resp, 0);
    chk("t6_idle_grant", grant, 0);
    pmem_resp = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom % 4 == 0) i_pmem_read = $urandom % 2;
      if ($urandom % 4 == 0) d_pmem_read = $urandom % 2;
      if ($urandom % 5 == 0) d_pmem_write = $urandom % 2;
      if ($urandom % 3 == 0) i_pmem_address = $urandom;
      if ($urandom % 3 == 0) d_pmem_address = $urandom;
      if ($urandom % 3 == 0)
        d_pmem_wdata = {8{$urandom}};
      pmem_rdata = {8{$urandom}};
      pmem_resp = ($urandom % 4 == 0);
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
